tqvp_crc_byte_feeder: RTL



---
 rtl/tqvp_crc_byte_feeder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/tqvp_crc_byte_feeder.sv
// Byte FIFO that streams CPU-written bytes into the CRC-32 stage over valid/ready,
// with an optional programmed length after which the stream stops.
module tqvp_crc_byte_feeder #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_clear
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic [7:0]           mem_r [FIFO_DEPTH];
  logic [PW-1:0]        rd_ptr_r;
  logic [PW-1:0]        wr_ptr_r;
  logic [LW-1:0]        level_r;
  logic [LEN_WIDTH-1:0] len_r;
  logic [LEN_WIDTH-1:0] cnt_r;
  logic                 overflow_r;
  logic                 done_r;
  logic                 out_clear_r;

  logic                 empty_s;
  logic                 full_s;
  logic                 valid_s;
  logic                 xfer_s;
  logic                 ctrl_wr_s;
  logic                 clear_s;
  logic                 start_s;
  logic                 push_s;
  logic                 push_ok_s;
  logic [LEN_WIDTH-1:0] cnt_next_s;
  logic [15:0]          len16_s;
  logic [15:0]          cnt16_s;
  logic [7:0]           level8_s;
  logic [7:0]           status_s;
  logic                 unused_s;

  assign unused_s = ^ui_in;
  assign uo_out   = 8'h00;

  // Handshake, register-write decode and status assembly
  always_comb begin
    empty_s    = (level_r == LW'(0));
    full_s     = (level_r == LW'(FIFO_DEPTH));
    valid_s    = !empty_s && (state_r != ST_DONE);
    xfer_s     = valid_s && out_ready;
    ctrl_wr_s  = data_write && (address == 4'h0);
    clear_s    = ctrl_wr_s && data_in[0];
    start_s    = ctrl_wr_s && data_in[1];
    push_s     = data_write && (address == 4'h1);
    // fullness is judged before any same-cycle pop
    push_ok_s  = push_s && !full_s;
    cnt_next_s = cnt_r + LEN_WIDTH'(1);
    len16_s    = 16'(len_r);
    cnt16_s    = 16'(cnt_r);
    level8_s   = 8'(level_r);
    status_s   = {level8_s[2:0], done_r, (state_r == ST_RUN), overflow_r, full_s, empty_s};
  end

  // CPU read mux
  always_comb begin
    data_out = 8'h00;
    case (address)
      4'h0:    data_out = status_s;
      4'h2:    data_out = len16_s[7:0];
      4'h3:    data_out = len16_s[15:8];
      4'h4:    data_out = cnt16_s[7:0];
      4'h5:    data_out = cnt16_s[15:8];
      default: data_out = 8'h00;
    endcase
  end

  assign out_valid = valid_s;
  assign out_data  = valid_s ? mem_r[rd_ptr_r] : 8'h00;
  assign out_clear = out_clear_r;

  // FIFO storage; entries are only observed through the valid-gated head
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Pointers, level, counters and stream FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      rd_ptr_r    <= PW'(0);
      wr_ptr_r    <= PW'(0);
      level_r     <= LW'(0);
      len_r       <= LEN_WIDTH'(0);
      cnt_r       <= LEN_WIDTH'(0);
      overflow_r  <= 1'b0;
      done_r      <= 1'b0;
      out_clear_r <= 1'b0;
    end else begin
      out_clear_r <= clear_s;

      if (clear_s) begin
        rd_ptr_r   <= PW'(0);
        wr_ptr_r   <= PW'(0);
        level_r    <= LW'(0);
        cnt_r      <= LEN_WIDTH'(0);
        overflow_r <= 1'b0;
        done_r     <= 1'b0;
        state_r    <= ST_IDLE;
      end else begin
        if (push_s && full_s) begin
          overflow_r <= 1'b1;
        end
        if (push_ok_s) begin
          wr_ptr_r <= wr_ptr_r + PW'(1);
        end
        if (xfer_s) begin
          rd_ptr_r <= rd_ptr_r + PW'(1);
        end
        case ({push_ok_s, xfer_s})
          2'b10:   level_r <= level_r + LW'(1);
          2'b01:   level_r <= level_r - LW'(1);
          default: level_r <= level_r;
        endcase

        case (state_r)
          ST_IDLE: begin
            if (xfer_s) begin
              cnt_r <= cnt_next_s;
            end
          end
          ST_RUN: begin
            if (xfer_s) begin
              cnt_r <= cnt_next_s;
              if (cnt_next_s == len_r) begin
                state_r <= ST_DONE;
                done_r  <= 1'b1;
              end
            end
          end
          ST_DONE: done_r  <= 1'b1;
          default: state_r <= ST_IDLE;
        endcase
      end

      // START after any same-write CLEAR, so a combined write lands in RUN/DONE
      if (start_s && (clear_s || (state_r == ST_IDLE))) begin
        cnt_r   <= LEN_WIDTH'(0);
        state_r <= (len_r == LEN_WIDTH'(0)) ? ST_DONE : ST_RUN;
      end

      if (data_write && (address == 4'h2)) begin
        len_r <= LEN_WIDTH'({len16_s[15:8], data_in});
      end else if (data_write && (address == 4'h3)) begin
        len_r <= LEN_WIDTH'({data_in, len16_s[7:0]});
      end
    end
  end

endmodule
